// File: rtl/fpm_pkg.sv
// Shared types and constants for the fp32 multiplier stream adapter.
// FP_QNAN and FP_INF are reference encodings for the test bench.
package fpm_pkg;

    localparam int unsigned FP32_W = 32;

    localparam logic [FP32_W-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP32_W-1:0] FP_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        StIdle,
        StSendA,
        StSendB,
        StWaitRes
    } fpm_state_e;

    typedef struct packed {
        logic [FP32_W-1:0] a;
        logic [FP32_W-1:0] b;
    } fpm_pair_t;

endpackage

// File: rtl/fpm_operand_fifo.sv
// Show-ahead synchronous FIFO for operand pairs; DEPTH must be a power of two.
// Pointers wrap naturally, so a separate occupancy count tells full from empty.
module fpm_operand_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fpm_stream_adapter.sv
// Feeds operand pairs to the fp32 multiplier over its shared operand bus (A then B)
// and returns products on a valid/ready stream; one multiply in flight at a time.
module fpm_stream_adapter
    import fpm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FP32_W-1:0] in_a,
    input  logic [FP32_W-1:0] in_b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FP32_W-1:0] mul_number_in,
    output logic              mul_a_valid,
    input  logic              mul_a_ready,
    output logic              mul_b_valid,
    input  logic              mul_b_ready,
    input  logic [FP32_W-1:0] mul_number_out,
    input  logic              mul_result_valid,
    output logic [FP32_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fpm_state_e        state_q;
    logic [FP32_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  ops_count_q;
    logic              in_ready_q, in_ready_d;

    fpm_pair_t         head;
    logic [CW-1:0]     fifo_count, count_next;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = (state_q == StSendB) && mul_b_ready;

    fpm_operand_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2 * FP32_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // in_ready is registered from the post-update occupancy so it is exact each cycle.
    always_comb begin
        count_next = fifo_count;
        if (push) count_next = count_next + CW'(1);
        if (pop)  count_next = count_next - CW'(1);
        in_ready_d = (count_next < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ops_count_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle:    if (!fifo_empty) state_q <= StSendA;
                StSendA:   if (mul_a_ready) state_q <= StSendB;
                StSendB:   if (mul_b_ready) state_q <= StWaitRes;
                StWaitRes: begin
                    // Result valid is a held level, so waiting on a full output is lossless.
                    if (mul_result_valid && (!out_valid_q || out_ready)) begin
                        out_data_q  <= mul_number_out;
                        out_valid_q <= 1'b1;
                        ops_count_q <= ops_count_q + CNT_W'(1);
                        state_q     <= StIdle;
                    end
                end
                default:   state_q <= StIdle;
            endcase
        end
    end

    // Valid is gated by ready: the multiplier only captures once it has raised ready.
    always_comb begin
        mul_number_in = '0;
        mul_a_valid   = 1'b0;
        mul_b_valid   = 1'b0;
        unique case (state_q)
            StSendA: begin
                mul_number_in = head.a;
                mul_a_valid   = mul_a_ready;
            end
            StSendB: begin
                mul_number_in = head.b;
                mul_b_valid   = mul_b_ready;
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ops_count = ops_count_q;
    assign busy      = (state_q != StIdle) || !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_fpm_stream_adapter.sv
// Bench for fpm_stream_adapter: a table-driven multiplier model plus an output scoreboard.
module tb_fpm_stream_adapter;
    import fpm_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int          MUL_LAT    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       in_a = '0, in_b = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       mul_number_in;
    logic              mul_a_valid, mul_b_valid;
    logic              mul_a_ready = 1'b0, mul_b_ready = 1'b0;
    logic [31:0]       mul_number_out = '0;
    logic              mul_result_valid = 1'b0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic [CNT_W-1:0]  ops_count;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int exp_ops  = 0;

    logic [63:0] op_q [$];
    logic [31:0] exp_q [$];

    logic hold_a = 1'b0, hold_b = 1'b0, hold_res = 1'b0;
    int   phase = 0;
    int   lat   = 0;
    logic [31:0] cap_a = '0, cap_b = '0;

    always #5 clk = ~clk;

    fpm_stream_adapter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mul_number_in    (mul_number_in),
        .mul_a_valid      (mul_a_valid),
        .mul_a_ready      (mul_a_ready),
        .mul_b_valid      (mul_b_valid),
        .mul_b_ready      (mul_b_ready),
        .mul_number_out   (mul_number_out),
        .mul_result_valid (mul_result_valid),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .busy             (busy),
        .ops_count        (ops_count)
    );

    function automatic logic [31:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h3FC00000_3FC00000: return 32'h40100000;
            64'h3F800000_3F800000: return 32'h3F800000;
            64'h40000000_3F800000: return 32'h40000000;
            64'h40400000_3F800000: return 32'h40400000;
            64'h40800000_3F800000: return 32'h40800000;
            64'h40A00000_3F800000: return 32'h40A00000;
            64'h7F800000_00000000: return FP_QNAN;
            64'h7F800000_BF800000: return 32'hFF800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    // Multiplier model: ready/valid capture of A then B, fixed latency, result held as a level.
    always @(posedge clk) begin
        if (rst) begin
            mul_a_ready      <= 1'b0;
            mul_b_ready      <= 1'b0;
            mul_result_valid <= 1'b0;
            phase            <= 0;
        end else begin
            case (phase)
                0: begin
                    mul_a_ready <= !hold_a;
                    if (mul_a_valid && mul_a_ready) begin
                        n_checks++;
                        if (op_q.size() == 0 || mul_number_in !== op_q[0][63:32]) begin
                            n_fail++;
                            $display("FAIL operand_a: got %h, want %h (queued %0d)",
                                     mul_number_in, (op_q.size() != 0) ? op_q[0][63:32] : 32'h0,
                                     op_q.size());
                        end
                        cap_a            <= mul_number_in;
                        mul_result_valid <= 1'b0;
                        mul_a_ready      <= 1'b0;
                        mul_b_ready      <= !hold_b;
                        phase            <= 1;
                    end
                end
                1: begin
                    mul_b_ready <= !hold_b;
                    if (mul_b_valid && mul_b_ready) begin
                        n_checks++;
                        if (op_q.size() == 0 || mul_number_in !== op_q[0][31:0]) begin
                            n_fail++;
                            $display("FAIL operand_b: got %h, want %h (queued %0d)",
                                     mul_number_in, (op_q.size() != 0) ? op_q[0][31:0] : 32'h0,
                                     op_q.size());
                        end
                        if (op_q.size() != 0) void'(op_q.pop_front());
                        cap_b       <= mul_number_in;
                        mul_b_ready <= 1'b0;
                        lat         <= MUL_LAT;
                        phase       <= 2;
                    end
                end
                default: begin
                    if (lat != 0) begin
                        lat <= lat - 1;
                    end else if (!hold_res) begin
                        mul_number_out   <= fmul_lut(cap_a, cap_b);
                        mul_result_valid <= 1'b1;
                        mul_a_ready      <= !hold_a;
                        phase            <= 0;
                    end
                end
            endcase
        end
    end

    // Protocol checks and output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        n_checks++;
        if ((mul_a_valid && !mul_a_ready) || (mul_b_valid && !mul_b_ready) ||
            (mul_a_valid && mul_b_valid)) begin
            n_fail++;
            $display("FAIL mul_protocol: a_v=%b a_r=%b b_v=%b b_r=%b, want valid only with ready",
                     mul_a_valid, mul_a_ready, mul_b_valid, mul_b_ready);
        end
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got %h, want no output", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL out_data: got %h, want %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls form a back-to-back stream.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] prod, input bit expect_out);
        bit ok;
        bit done;
        done = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            ok = in_ready;
            step(1);
            if (ok) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready got 0, want 1 within 300 cycles");
        end else begin
            op_q.push_back({a, b});
            if (expect_out) begin
                exp_q.push_back(prod);
                exp_ops++;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !busy && !out_valid) break;
            step(1);
        end
        n_checks++;
        if (i == 500) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, busy=%b, want 0 pending, busy=0",
                     exp_q.size(), busy);
        end
    endtask

    task automatic check_ops(input string name);
        n_checks++;
        if (ops_count !== CNT_W'(exp_ops)) begin
            n_fail++;
            $display("FAIL %s ops_count: got %0d, want %0d", name, ops_count, exp_ops);
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        op_q.delete();
        exp_q.delete();
        exp_ops = 0;
        step(n);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || ops_count !== '0 ||
            mul_a_valid !== 1'b0 || mul_b_valid !== 1'b0 || mul_number_in !== '0 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b ov=%b od=%h cnt=%0d av=%b bv=%b num=%h busy=%b, want all 0",
                     in_ready, out_valid, out_data, ops_count, mul_a_valid, mul_b_valid,
                     mul_number_in, busy);
        end
        rst = 1'b0;
        step(1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        push_pair(32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
        idle_in();
        wait_drain();
        check_ops("basic");
    endtask

    task automatic test_stall();
        int i;
        int hs0;
        bit seen;
        out_ready = 1'b0;
        push_pair(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b1);
        idle_in();
        seen = 1'b0;
        for (i = 0; i < 200 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else step(1);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stall_out_valid: got 0, want 1 within 200 cycles");
        end
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h40100000 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got ov=%b od=%h rdy=%b, want 1 40100000 1",
                         k, out_valid, out_data, in_ready);
            end
            step(1);
        end
        hs0 = hs_count;
        out_ready = 1'b1;
        step(6);
        n_checks++;
        if (hs_count != hs0 + 1) begin
            n_fail++;
            $display("FAIL stall_release handshakes: got %0d, want 1", hs_count - hs0);
        end
        wait_drain();
        check_ops("stall");
    endtask

    task automatic test_back_to_back();
        logic [31:0] k_val [5];
        k_val[0] = 32'h3F800000;
        k_val[1] = 32'h40000000;
        k_val[2] = 32'h40400000;
        k_val[3] = 32'h40800000;
        k_val[4] = 32'h40A00000;
        hold_a = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) push_pair(k_val[k], 32'h3F800000, k_val[k], 1'b1);
        in_a = k_val[4];
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL full_in_ready cycle %0d: got %b, want 0", k, in_ready);
            end
            step(1);
        end
        hold_a = 1'b0;
        push_pair(k_val[4], 32'h3F800000, k_val[4], 1'b1);
        idle_in();
        wait_drain();
        check_ops("back_to_back");
    endtask

    task automatic test_special();
        push_pair(FP_INF, 32'h00000000, FP_QNAN, 1'b1);
        push_pair(FP_INF, 32'hBF800000, 32'hFF800000, 1'b1);
        idle_in();
        wait_drain();
        check_ops("special");
    endtask

    task automatic check_after_reset(input string name);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s out_valid cycle %0d: got %b, want 0", name, k, out_valid);
            end
            step(1);
        end
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || ops_count !== '0) begin
            n_fail++;
            $display("FAIL %s post_state: got busy=%b rdy=%b cnt=%0d, want 0 1 0",
                     name, busy, in_ready, ops_count);
        end
    endtask

    task automatic test_reset_mid();
        // Stall in SEND_B with a second pair queued behind.
        hold_b = 1'b1;
        step(1);
        push_pair(32'h40000000, 32'h40400000, 32'h0, 1'b0);
        push_pair(32'h3FC00000, 32'h3FC00000, 32'h0, 1'b0);
        idle_in();
        step(8);
        n_checks++;
        if (mul_number_in !== 32'h40400000 || mul_b_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL send_b_stall: got num=%h bv=%b busy=%b, want 40400000 0 1",
                     mul_number_in, mul_b_valid, busy);
        end
        hold_b = 1'b0;
        apply_reset(2);
        check_after_reset("rst_send_b");

        hold_res = 1'b1;
        push_pair(32'h40000000, 32'h40400000, 32'h0, 1'b0);
        idle_in();
        step(15);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || mul_number_in !== '0) begin
            n_fail++;
            $display("FAIL wait_res_stall: got ov=%b busy=%b num=%h, want 0 1 0",
                     out_valid, busy, mul_number_in);
        end
        hold_res = 1'b0;
        apply_reset(2);
        check_after_reset("rst_wait_res");

        push_pair(32'h40000000, 32'h40400000, 32'h40C00000, 1'b1);
        idle_in();
        wait_drain();
        check_ops("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_special();
        test_reset_mid();
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
